// File: rtl/mem_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stream_if
//  Description : Handshake and data bundle for the MEM pipeline stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stream_if;
    logic        EXE_to_MEM_valid;
    logic        WB_allowin;
    logic [31:0] MEM_pc_in;
    logic [31:0] MEM_alu_res_in;
    logic        MEM_res_from_mem_in;
    logic        MEM_rf_we_in;
    logic [4:0]  MEM_rf_waddr_in;
    logic [31:0] data_sram_rdata;

    logic        MEM_allowin;
    logic        MEM_to_WB_valid;
    logic [31:0] MEM_pc_out;
    logic [31:0] MEM_final_res_out;
    logic        MEM_rf_we_out;
    logic [4:0]  MEM_rf_waddr_out;
    logic        MEM_bypass_valid_out;
    logic [31:0] MEM_bypass_data_out;

    modport slave (
        input  EXE_to_MEM_valid, WB_allowin, MEM_pc_in, MEM_alu_res_in,
               MEM_res_from_mem_in, MEM_rf_we_in, MEM_rf_waddr_in, data_sram_rdata,
        output MEM_allowin, MEM_to_WB_valid, MEM_pc_out, MEM_final_res_out,
               MEM_rf_we_out, MEM_rf_waddr_out, MEM_bypass_valid_out, MEM_bypass_data_out
    );

    modport master (
        output EXE_to_MEM_valid, WB_allowin, MEM_pc_in, MEM_alu_res_in,
               MEM_res_from_mem_in, MEM_rf_we_in, MEM_rf_waddr_in, data_sram_rdata,
        input  MEM_allowin, MEM_to_WB_valid, MEM_pc_out, MEM_final_res_out,
               MEM_rf_we_out, MEM_rf_waddr_out, MEM_bypass_valid_out, MEM_bypass_data_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_stream.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stream
//  Description : MEM pipeline stage with valid/allowin handshake and optional
//                load-data hold register (macro MEM_LOAD_HOLD_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stream (
    input  wire logic   clk,
    input  wire logic   resetn,
    mem_stream_if.slave bus
);

    logic        r_mem_valid;
    logic [31:0] r_pc;
    logic [31:0] r_alu_res;
    logic        r_res_from_mem;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;

    logic        w_allowin;
    logic        w_accept;
    logic [31:0] w_load_data;
    logic [31:0] w_final_res;

    // Ready-go is always 1, so the stage frees up whenever WB takes the occupant.
    assign w_allowin = !r_mem_valid || bus.WB_allowin;
    assign w_accept  = bus.EXE_to_MEM_valid && w_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid    <= 1'b0;
            r_pc           <= 32'd0;
            r_alu_res      <= 32'd0;
            r_res_from_mem <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'd0;
        end else begin
            if (w_allowin) begin
                r_mem_valid <= bus.EXE_to_MEM_valid;
            end
            if (w_accept) begin
                r_pc           <= bus.MEM_pc_in;
                r_alu_res      <= bus.MEM_alu_res_in;
                r_res_from_mem <= bus.MEM_res_from_mem_in;
                r_rf_we        <= bus.MEM_rf_we_in;
                r_rf_waddr     <= bus.MEM_rf_waddr_in;
            end
        end
    end

`ifdef MEM_LOAD_HOLD_EN
    logic        r_rdata_held;
    logic [31:0] r_hold_reg;
    logic        w_capture;

    // SRAM data is only valid in the first MEM cycle; keep it if WB stalls us.
    assign w_capture = r_mem_valid && r_res_from_mem && !r_rdata_held && !bus.WB_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata_held <= 1'b0;
            r_hold_reg   <= 32'd0;
        end else if (w_allowin) begin
            r_rdata_held <= 1'b0;
        end else if (w_capture) begin
            r_rdata_held <= 1'b1;
            r_hold_reg   <= bus.data_sram_rdata;
        end
    end

    assign w_load_data = r_rdata_held ? r_hold_reg : bus.data_sram_rdata;
`else
    assign w_load_data = bus.data_sram_rdata;
`endif

    assign w_final_res = r_res_from_mem ? w_load_data : r_alu_res;

    assign bus.MEM_allowin          = w_allowin;
    assign bus.MEM_to_WB_valid      = r_mem_valid;
    assign bus.MEM_pc_out           = r_pc;
    assign bus.MEM_final_res_out    = w_final_res;
    assign bus.MEM_rf_we_out        = r_mem_valid && r_rf_we;
    assign bus.MEM_rf_waddr_out     = r_rf_waddr;
    assign bus.MEM_bypass_valid_out = r_mem_valid && r_rf_we && (r_rf_waddr != 5'd0);
    assign bus.MEM_bypass_data_out  = w_final_res;

endmodule
`default_nettype wire

// File: tb/tb_mem_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stream
//  Description : Randomized self-checking bench for mem_stream against an
//                occupancy-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stream;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_stream_if bus ();

    mem_stream dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what instruction sits in MEM, how long it has been there,
    // and the SRAM word seen in its first cycle.
    bit          m_v;
    bit          m_ld;
    bit          m_we;
    logic [31:0] m_pc;
    logic [31:0] m_alu;
    logic [31:0] m_cap;
    logic [4:0]  m_wa;
    int          m_age;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_final();
        if (!m_ld) return m_alu;
`ifdef MEM_LOAD_HOLD_EN
        if (m_age > 0) return m_cap;
`endif
        return bus.data_sram_rdata;
    endfunction

    task automatic model_check();
        logic [31:0] exp_final;
        check("allowin", 32'(bus.MEM_allowin), 32'(!m_v || bus.WB_allowin));
        check("to_wb_valid", 32'(bus.MEM_to_WB_valid), 32'(m_v));
        check("rf_we_out", 32'(bus.MEM_rf_we_out), 32'(m_v && m_we));
        check("bypass_valid", 32'(bus.MEM_bypass_valid_out), 32'(m_v && m_we && (m_wa != 5'd0)));
        if (m_v) begin
            exp_final = model_final();
            check("pc_out", bus.MEM_pc_out, m_pc);
            check("final_res", bus.MEM_final_res_out, exp_final);
            check("bypass_data", bus.MEM_bypass_data_out, exp_final);
            check("waddr_out", 32'(bus.MEM_rf_waddr_out), 32'(m_wa));
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] alu,
                         input bit ld, input bit we, input logic [4:0] wa,
                         input bit wb, input logic [31:0] rd);
        bus.EXE_to_MEM_valid    = v;
        bus.MEM_pc_in           = pc;
        bus.MEM_alu_res_in      = alu;
        bus.MEM_res_from_mem_in = ld;
        bus.MEM_rf_we_in        = we;
        bus.MEM_rf_waddr_in     = wa;
        bus.WB_allowin          = wb;
        bus.data_sram_rdata     = rd;
        #3;
        model_check();
    endtask

    task automatic tick();
        bit allow;
        @(posedge clk);
        allow = !m_v || bus.WB_allowin;
        if (allow) begin
            m_v = bus.EXE_to_MEM_valid;
            if (bus.EXE_to_MEM_valid) begin
                m_pc  = bus.MEM_pc_in;
                m_alu = bus.MEM_alu_res_in;
                m_ld  = bus.MEM_res_from_mem_in;
                m_we  = bus.MEM_rf_we_in;
                m_wa  = bus.MEM_rf_waddr_in;
                m_age = 0;
            end
        end else begin
            if (m_age == 0) m_cap = bus.data_sram_rdata;
            m_age++;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_allowin"}, 32'(bus.MEM_allowin), 32'd1);
        check({tag, "_to_wb"}, 32'(bus.MEM_to_WB_valid), 32'd0);
        check({tag, "_pc"}, bus.MEM_pc_out, 32'd0);
        check({tag, "_final"}, bus.MEM_final_res_out, 32'd0);
        check({tag, "_rf_we"}, 32'(bus.MEM_rf_we_out), 32'd0);
        check({tag, "_waddr"}, 32'(bus.MEM_rf_waddr_out), 32'd0);
        check({tag, "_bypass"}, 32'(bus.MEM_bypass_valid_out), 32'd0);
    endtask

    task automatic rand_cycle(input bit force_offer, input bit force_wb);
        bit v;
        bit wb;
        bit ld;
        v  = force_offer || ($urandom_range(0, 9) < 7);
        wb = force_wb || ($urandom_range(0, 9) < 6);
        ld = $urandom_range(0, 1) == 1;
`ifndef MEM_LOAD_HOLD_EN
        // Without hold storage a load in MEM must never be stalled.
        if (m_v && m_ld) wb = 1'b1;
`endif
        drive(v, $urandom, $urandom, ld, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 31)), wb, $urandom);
        tick();
    endtask

    initial begin
        m_v = 0; m_ld = 0; m_we = 0; m_pc = '0; m_alu = '0; m_cap = '0; m_wa = '0; m_age = 0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.EXE_to_MEM_valid    = $urandom_range(0, 1) == 1;
            bus.WB_allowin          = $urandom_range(0, 1) == 1;
            bus.MEM_pc_in           = $urandom;
            bus.MEM_alu_res_in      = $urandom;
            bus.MEM_res_from_mem_in = $urandom_range(0, 1) == 1;
            bus.MEM_rf_we_in        = 1'b1;
            bus.MEM_rf_waddr_in     = 5'($urandom_range(1, 31));
            bus.data_sram_rdata     = $urandom;
            @(negedge clk);
            check_reset_outputs("rst");
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        drive(0, $urandom, $urandom, 0, 1, 5'd3, 1, $urandom);
        check_reset_outputs("post_rst");
        tick();

        // ALU pass-through
        drive(1, 32'h1c000000, 32'h12345678, 0, 1, 5'd5, 1, $urandom);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, $urandom);
        check("alu_to_wb", 32'(bus.MEM_to_WB_valid), 32'd1);
        check("alu_final", bus.MEM_final_res_out, 32'h12345678);
        check("alu_bypass", 32'(bus.MEM_bypass_valid_out), 32'd1);
        tick();

        // Load, no stall
        drive(1, 32'h1c000004, 32'h00001000, 1, 1, 5'd9, 1, $urandom);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, 32'hdeadbeef);
        check("ld_final", bus.MEM_final_res_out, 32'hdeadbeef);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, $urandom);
        check("ld_gone", 32'(bus.MEM_to_WB_valid), 32'd0);
        tick();

`ifdef MEM_LOAD_HOLD_EN
        // Load stalled three cycles while SRAM data moves on
        drive(1, 32'h1c000008, 32'h00002000, 1, 1, 5'd10, 1, $urandom);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1c00000c, 32'h0badf00d, 0, 1, 5'd11, i == 3,
                  (i == 0) ? 32'hcafef00d : 32'h0);
            check("stall_final", bus.MEM_final_res_out, 32'hcafef00d);
            check("stall_allowin", 32'(bus.MEM_allowin), 32'(i == 3));
            tick();
        end
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, 32'h0);
        check("after_stall_final", bus.MEM_final_res_out, 32'h0badf00d);
        tick();
`endif

        // Write to r0 is not bypassed
        drive(1, 32'h1c000010, 32'h77777777, 0, 1, 5'd0, 1, $urandom);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, $urandom);
        check("r0_bypass", 32'(bus.MEM_bypass_valid_out), 32'd0);
        check("r0_rf_we", 32'(bus.MEM_rf_we_out), 32'd1);
        tick();

        // Random traffic
        for (int i = 0; i < 600; i++) rand_cycle(0, 0);

        // Back-to-back with WB always ready: must never bubble
        for (int i = 0; i < 30; i++) begin
            rand_cycle(1, 1);
            check("b2b_valid", 32'(bus.MEM_to_WB_valid), 32'd1);
        end

        // Reset asserted while an instruction is stalled
`ifdef MEM_LOAD_HOLD_EN
        drive(1, 32'h1c000020, 32'h00003000, 1, 1, 5'd12, 1, $urandom);
`else
        drive(1, 32'h1c000020, 32'h00003000, 0, 1, 5'd12, 1, $urandom);
`endif
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 0, 32'h55aa55aa);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 0, 32'h0);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_v = 0;
        @(posedge clk);
        #1 resetn = 1'b1;
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 0, 32'h13572468);
        check_reset_outputs("after_mid_rst");
        tick();
        drive(1, 32'h1c000030, 32'h24680000, 0, 1, 5'd4, 1, $urandom);
        tick();
        drive(0, $urandom, $urandom, 0, 0, 5'd0, 1, 32'h55aa55aa);
        check("fresh_final", bus.MEM_final_res_out, 32'h24680000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
